// File: rtl/node_worklist_sched.sv
// node_worklist_sched: ready-node worklist for a Kahn-style topological walk.
// Seeds the start node, queues nodes whose in-degree reached zero, issues them
// one at a time to the edge-walk datapath with a cap on in-flight nodes, and
// reports run completion or a lost worklist push.
module node_worklist_sched #(
    parameter int PARAM_NODE_IDX_WIDTH  = 10,
    parameter int PARAM_FIFO_DEPTH      = 32,
    parameter int PARAM_MAX_OUTSTANDING = 4,
    parameter int PARAM_COUNTER_WIDTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            part_sel,
    input  logic                            start_run,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0] start_node_p1,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0] start_node_p2,
    input  logic                            ready_valid,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0] ready_node,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [PARAM_NODE_IDX_WIDTH-1:0] node_idx,
    input  logic                            retire,
    output logic                            busy,
    output logic                            run_done,
    output logic                            overflow_err,
    output logic [PARAM_NODE_IDX_WIDTH:0]   nodes_processed
);

    localparam int NW = PARAM_NODE_IDX_WIDTH;
    localparam int AW = $clog2(PARAM_FIFO_DEPTH);
    localparam int CW = PARAM_COUNTER_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    logic [NW-1:0]   r_seed;
    logic [NW-1:0]   r_mem [PARAM_FIFO_DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [CW-1:0]   r_outstanding;
    logic [NW:0]     r_nodes_processed;
    logic            r_busy;
    logic            r_run_done;
    logic            r_overflow;

    logic            w_start;
    logic            w_in_run;
    logic            w_empty;
    logic            w_full;
    logic            w_below_max;
    logic            w_issue_valid;
    logic            w_pop;
    logic            w_retire;
    logic            w_push;
    logic            w_ovf;
    logic            w_done;
    logic            w_wr_en;
    logic [NW-1:0]   w_wr_data;
    logic [NW-1:0]   w_head;

    // A run may only be (re)started from IDLE or from the error state.
    assign w_start     = start_run && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_in_run    = (r_state == S_RUN);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_below_max = (r_outstanding < CW'(PARAM_MAX_OUTSTANDING));

    assign w_issue_valid = w_in_run && !w_empty && w_below_max;
    assign w_pop         = w_issue_valid && issue_ready;
    // A retire with nothing in flight is spurious and dropped.
    assign w_retire      = w_in_run && retire && (r_outstanding != '0);
    // A full worklist still accepts a push when the head leaves this cycle.
    assign w_push        = w_in_run && ready_valid && (!w_full || w_pop);
    assign w_ovf         = w_in_run && ready_valid && w_full && !w_pop;
    assign w_done        = w_in_run && w_empty && (r_outstanding == '0) &&
                           !ready_valid && !w_pop && !w_retire;

    // The SEED cycle reuses the push path to load the start node.
    assign w_wr_en   = (r_state == S_SEED) || w_push;
    assign w_wr_data = (r_state == S_SEED) ? r_seed : ready_node;
    assign w_head    = r_mem[r_rptr[AW-1:0]];

    assign issue_valid     = w_issue_valid;
    assign node_idx        = (w_in_run && !w_empty) ? w_head : '0;
    assign busy            = r_busy;
    assign run_done        = r_run_done;
    assign overflow_err    = r_overflow;
    assign nodes_processed = r_nodes_processed;

    // Capture the seed node for the selected puzzle part when a run starts.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_seed <= part_sel ? start_node_p2 : start_node_p1;
        end
    end

    // Worklist storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[AW-1:0]] <= w_wr_data;
        end
    end

    // Worklist pointers, cleared at the start of every run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_start) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    // Count of issued-but-not-retired nodes; issue and retire together cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else if (w_start) begin
            r_outstanding <= '0;
        end else begin
            case ({w_pop, w_retire})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Saturating count of retired nodes for the current run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nodes_processed <= '0;
        end else if (w_start) begin
            r_nodes_processed <= '0;
        end else if (w_retire && (r_nodes_processed != '1)) begin
            r_nodes_processed <= r_nodes_processed + (NW+1)'(1);
        end
    end

    // Run-control FSM with registered busy, run_done and overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_run_done <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ERR: begin
                    r_run_done <= 1'b0;
                    if (start_run) begin
                        r_state    <= S_SEED;
                        r_busy     <= 1'b1;
                        r_overflow <= 1'b0;
                    end
                end
                S_SEED: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_ovf) begin
                        r_state    <= S_ERR;
                        r_busy     <= 1'b0;
                        r_overflow <= 1'b1;
                    end else if (w_done) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_run_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_run_done <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_run_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_node_worklist_sched.sv
// Self-checking bench for node_worklist_sched: a reset-state check, a
// cycle table for the basic run, directed corner sequences and randomized
// traffic against a queue-based reference model.
module tb_node_worklist_sched;

    localparam int NW    = 10;
    localparam int DEPTH = 32;
    localparam int MAXO  = 4;
    localparam int CW    = 4;
    localparam int NPMAX = (1 << (NW + 1)) - 1;

    localparam int M_IDLE = 0;
    localparam int M_SEED = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;
    localparam int M_ERR  = 4;

    logic          clk;
    logic          rst_n;
    logic          part_sel;
    logic          start_run;
    logic [NW-1:0] start_node_p1;
    logic [NW-1:0] start_node_p2;
    logic          ready_valid;
    logic [NW-1:0] ready_node;
    logic          issue_valid;
    logic          issue_ready;
    logic [NW-1:0] node_idx;
    logic          retire;
    logic          busy;
    logic          run_done;
    logic          overflow_err;
    logic [NW:0]   nodes_processed;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_mode;
    int m_q[$];
    int m_out;
    int m_np;
    int m_ovf;
    int m_seed;

    typedef struct {
        int start, psel, ir, rv, rnode, ret;
        int e_iv, e_node, e_busy, e_done, e_ovf, e_np;
    } vec_t;

    vec_t tbl[9];

    node_worklist_sched #(
        .PARAM_NODE_IDX_WIDTH (NW),
        .PARAM_FIFO_DEPTH     (DEPTH),
        .PARAM_MAX_OUTSTANDING(MAXO),
        .PARAM_COUNTER_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .part_sel       (part_sel),
        .start_run      (start_run),
        .start_node_p1  (start_node_p1),
        .start_node_p2  (start_node_p2),
        .ready_valid    (ready_valid),
        .ready_node     (ready_node),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .node_idx       (node_idx),
        .retire         (retire),
        .busy           (busy),
        .run_done       (run_done),
        .overflow_err   (overflow_err),
        .nodes_processed(nodes_processed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_node_out();
        return (m_mode == M_RUN && m_q.size() > 0) ? m_q[0] : 0;
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, "_issue_valid"}, int'(issue_valid),
            int'(m_mode == M_RUN && m_q.size() > 0 && m_out < MAXO));
        chk({tag, "_node_idx"}, int'(node_idx), m_node_out());
        chk({tag, "_busy"}, int'(busy), int'(m_mode == M_SEED || m_mode == M_RUN));
        chk({tag, "_run_done"}, int'(run_done), int'(m_mode == M_DONE));
        chk({tag, "_overflow_err"}, int'(overflow_err), m_ovf);
        chk({tag, "_nodes_processed"}, int'(nodes_processed), m_np);
    endtask

    // One clock of the specification's rules, applied to the sampled inputs.
    task automatic model_step();
        bit pop, ret, push, lost, fin;
        case (m_mode)
            M_IDLE, M_ERR: begin
                if (start_run) begin
                    m_seed = part_sel ? int'(start_node_p2) : int'(start_node_p1);
                    m_q.delete();
                    m_out  = 0;
                    m_np   = 0;
                    m_ovf  = 0;
                    m_mode = M_SEED;
                end
            end
            M_SEED: begin
                m_q.push_back(m_seed);
                m_mode = M_RUN;
            end
            M_RUN: begin
                pop  = (m_q.size() > 0) && (m_out < MAXO) && issue_ready;
                ret  = retire && (m_out > 0);
                push = ready_valid && ((m_q.size() < DEPTH) || pop);
                lost = ready_valid && !push;
                fin  = (m_q.size() == 0) && (m_out == 0) && !ready_valid && !pop && !ret;
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(int'(ready_node));
                m_out = m_out + int'(pop) - int'(ret);
                if (ret && m_np < NPMAX) m_np++;
                if (lost) begin
                    m_ovf  = 1;
                    m_mode = M_ERR;
                end else if (fin) begin
                    m_mode = M_DONE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic idle_in();
        start_run   = 1'b0;
        ready_valid = 1'b0;
        issue_ready = 1'b0;
        retire      = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        idle_in();
        rst_n  = 1'b0;
        m_mode = M_IDLE;
        m_q.delete();
        m_out  = 0;
        m_np   = 0;
        m_ovf  = 0;
        #2;
        compare_all(tag);
        chk({tag, "_iv_zero"}, int'(issue_valid), 0);
        chk({tag, "_busy_zero"}, int'(busy), 0);
        chk({tag, "_node_zero"}, int'(node_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_seed(input bit psel, input int seed, input string tag);
        idle_in();
        part_sel = psel;
        if (psel) start_node_p2 = NW'(seed);
        else      start_node_p1 = NW'(seed);
        start_run = 1'b1;
        cyc({tag, "_start"});
        start_run = 1'b0;
        cyc({tag, "_seed"});
    endtask

    task automatic push_node(input int n, input bit ir, input string tag);
        ready_valid = 1'b1;
        ready_node  = NW'(n);
        issue_ready = ir;
        cyc(tag);
        ready_valid = 1'b0;
        issue_ready = 1'b0;
    endtask

    initial begin
        int issued[$];
        int pushes[3];
        int pend, pidx, ndone, nis, snap;
        bit seed_ret, doiss, ret_now, rv_now;
        int p_rv, p_ir, p_ret;

        rst_n         = 1'b1;
        part_sel      = 1'b0;
        start_node_p1 = '0;
        start_node_p2 = '0;
        ready_node    = '0;
        idle_in();
        #1;
        do_reset("reset");

        // ---------------- table: single-node run, part 1 seed 5
        //            start psel ir rv rnode ret | iv node busy done ovf np
        tbl[0] = '{1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 0,   1, 5, 1, 0, 0, 0};
        tbl[2] = '{0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 1};
        tbl[6] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1};
        tbl[7] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1};
        tbl[8] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1};
        start_node_p1 = NW'(5);
        start_node_p2 = NW'(700);
        for (int i = 0; i < 9; i++) begin
            start_run   = (tbl[i].start != 0);
            part_sel    = (tbl[i].psel != 0);
            issue_ready = (tbl[i].ir != 0);
            ready_valid = (tbl[i].rv != 0);
            ready_node  = NW'(tbl[i].rnode);
            retire      = (tbl[i].ret != 0);
            cyc($sformatf("t1_model_%0d", i));
            chk($sformatf("t1_iv_%0d", i), int'(issue_valid), tbl[i].e_iv);
            chk($sformatf("t1_node_%0d", i), int'(node_idx), tbl[i].e_node);
            chk($sformatf("t1_busy_%0d", i), int'(busy), tbl[i].e_busy);
            chk($sformatf("t1_done_%0d", i), int'(run_done), tbl[i].e_done);
            chk($sformatf("t1_ovf_%0d", i), int'(overflow_err), tbl[i].e_ovf);
            chk($sformatf("t1_np_%0d", i), int'(nodes_processed), tbl[i].e_np);
        end
        idle_in();

        // ---------------- part 2 seed 700, then 12, 13, 14 in FIFO order
        start_seed(1'b1, 700, "t2");
        pushes = '{12, 13, 14};
        issued.delete();
        pend = 0; pidx = 0; ndone = 0; seed_ret = 1'b0;
        for (int k = 0; k < 40 && ndone == 0; k++) begin
            doiss       = issue_valid;
            ret_now     = (pend > 0);
            rv_now      = seed_ret && (pidx < 3);
            issue_ready = 1'b1;
            retire      = ret_now;
            ready_valid = rv_now;
            ready_node  = rv_now ? NW'(pushes[pidx]) : '0;
            if (doiss) issued.push_back(int'(node_idx));
            cyc("t2_run");
            if (ret_now) begin
                pend--;
                seed_ret = 1'b1;
            end
            if (rv_now) pidx++;
            if (doiss) pend++;
            if (run_done) ndone++;
        end
        chk("t2_done_seen", ndone, 1);
        chk("t2_np", int'(nodes_processed), 4);
        idle_in();
        for (int k = 0; k < 3; k++) begin
            cyc("t2_after");
            if (run_done) ndone++;
        end
        chk("t2_done_once", ndone, 1);
        chk("t2_issue_count", issued.size(), 4);
        if (issued.size() == 4) begin
            chk("t2_order0", issued[0], 700);
            chk("t2_order1", issued[1], 12);
            chk("t2_order2", issued[2], 13);
            chk("t2_order3", issued[3], 14);
        end

        // ---------------- outstanding limit, stall stability, issue+retire
        start_seed(1'b0, 100, "t3");
        for (int n = 101; n <= 105; n++) push_node(n, 1'b0, "t3_fill");
        nis = 0;
        for (int k = 0; k < 8; k++) begin
            if (issue_valid) nis++;
            issue_ready = 1'b1;
            cyc("t3_issue");
        end
        chk("t3_issue_count", nis, MAXO);
        chk("t3_capped_iv", int'(issue_valid), 0);
        chk("t3_capped_node", int'(node_idx), 104);
        issue_ready = 1'b1;
        retire      = 1'b1;
        cyc("t3_retire");
        chk("t3_reopen_iv", int'(issue_valid), 1);
        chk("t3_reopen_node", int'(node_idx), 104);
        cyc("t3_issue_and_retire");
        chk("t3_const_out_iv", int'(issue_valid), 1);
        chk("t3_const_out_node", int'(node_idx), 105);
        idle_in();
        snap = int'(node_idx);
        for (int k = 0; k < 5; k++) begin
            cyc("t3_stall");
            chk($sformatf("t3_stall_node_%0d", k), int'(node_idx), snap);
            chk($sformatf("t3_stall_iv_%0d", k), int'(issue_valid), 1);
        end
        do_reset("t3_rst");

        // ---------------- overflow at 33rd push, then retry with a pop
        start_seed(1'b0, 200, "t4");
        for (int n = 201; n <= 231; n++) push_node(n, 1'b0, "t4_fill");
        chk("t4_full_no_err", int'(overflow_err), 0);
        push_node(999, 1'b0, "t4_over");
        chk("t4_ovf_set", int'(overflow_err), 1);
        chk("t4_ovf_busy", int'(busy), 0);
        chk("t4_ovf_iv", int'(issue_valid), 0);
        ready_valid = 1'b1; retire = 1'b1; issue_ready = 1'b1;
        cyc("t4_err_ignore");
        chk("t4_err_sticky", int'(overflow_err), 1);
        idle_in();
        start_seed(1'b0, 200, "t4_retry");
        chk("t4_retry_cleared", int'(overflow_err), 0);
        for (int n = 201; n <= 231; n++) push_node(n, 1'b0, "t4_refill");
        push_node(998, 1'b1, "t4_push_pop");
        chk("t4_pp_no_err", int'(overflow_err), 0);
        chk("t4_pp_busy", int'(busy), 1);
        chk("t4_pp_head", int'(node_idx), 201);
        do_reset("t4_rst");

        // ---------------- reset mid-run with 3 queued, 2 outstanding
        start_seed(1'b0, 300, "t6");
        for (int n = 301; n <= 304; n++) push_node(n, 1'b0, "t6_fill");
        issue_ready = 1'b1;
        cyc("t6_iss0");
        cyc("t6_iss1");
        chk("t6_pre_head", int'(node_idx), 302);
        do_reset("t6_midrst");
        start_seed(1'b0, 1, "t6_new");
        issue_ready = 1'b1;
        cyc("t6_new_issue");
        issue_ready = 1'b0;
        retire      = 1'b1;
        cyc("t6_new_retire");
        retire = 1'b0;
        ndone  = 0;
        for (int k = 0; k < 10 && ndone == 0; k++) begin
            cyc("t6_wait");
            if (run_done) ndone++;
        end
        chk("t6_done_seen", ndone, 1);
        chk("t6_np", int'(nodes_processed), 1);
        cyc("t6_idle");

        // ---------------- nodes_processed saturation
        start_seed(1'b0, 0, "t7");
        for (int k = 0; k < NPMAX + 20; k++) begin
            ready_valid = 1'b1;
            ready_node  = NW'(k);
            issue_ready = 1'b1;
            retire      = 1'b1;
            cyc("t7_stream");
        end
        chk("t7_saturated", int'(nodes_processed), NPMAX);
        do_reset("t7_rst");

        // ---------------- randomized traffic against the model
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin p_rv = 30; p_ir = 70; p_ret = 50; end
                1:       begin p_rv = 70; p_ir = 10; p_ret = 20; end
                2:       begin p_rv = 20; p_ir = 90; p_ret = 80; end
                default: begin p_rv = 50; p_ir = 50; p_ret = 50; end
            endcase
            for (int k = 0; k < 600; k++) begin
                if ($urandom_range(0, 399) == 0) begin
                    do_reset("rnd_rst");
                end else begin
                    start_run     = ($urandom_range(0, 99) < 10);
                    part_sel      = $urandom_range(0, 1) != 0;
                    start_node_p1 = NW'($urandom_range(0, 1023));
                    start_node_p2 = NW'($urandom_range(0, 1023));
                    ready_valid   = ($urandom_range(0, 99) < p_rv);
                    ready_node    = NW'($urandom_range(0, 1023));
                    issue_ready   = ($urandom_range(0, 99) < p_ir);
                    retire        = ($urandom_range(0, 99) < p_ret);
                    cyc($sformatf("rnd%0d", ph));
                end
            end
        end
        idle_in();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
